mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory port between REQUESTERS cache controllers (e.g. I-cache, D-cache).
//  Each controller holds its memory request valid until its response arrives.
//  Round-robin grant; one transaction in flight; request fields latched at grant.
//  Sits between the controllers' *_MEM ports and the memory model/bus.
// PARAMETERS
//  REQUESTERS      2     number of requesting controllers (>=2)
//  ADDRESS_WIDTH   32    address width
//  CACHE_LINE_SIZE 32    data width per transfer (bits)
//  TIMEOUT_CYCLES  255   WAIT_RESP watchdog limit (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  clk             in   1                     clock, all state on posedge
//  rst             in   1                     asynchronous active-low reset
//  reqValid_IN     in   REQUESTERS            per-requester valid, held until respValid_OUT
//  reqAddress_IN   in   REQUESTERS*AW         packed; requester i at [i*AW +: AW]
//  reqData_IN      in   REQUESTERS*LINE       packed write data
//  reqWen_IN       in   REQUESTERS            1 = write, 0 = read
//  respValid_OUT   out  REQUESTERS            one-cycle one-hot response pulse
//  respData_OUT    out  LINE                  latched read data, valid with respValid_OUT
//  respErr_OUT     out  1                     timeout flag, valid with respValid_OUT
//  memReqValid     out  1                     request to memory
//  memReqReady     in   1                     memory accepts when valid&ready
//  memReqAddress   out  AW                    latched address
//  memReqData      out  LINE                  latched write data
//  memReqWen       out  1                     latched write enable
//  memRespValid    in   1                     memory response (reads and write acks)
//  memRespData     in   LINE                  read data
//  grantId         out  clog2(REQUESTERS)     current/last granted requester
//  busy            out  1                     high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rrPtr=0, grantId=0, all outputs 0, latches 0.
//  FSM: IDLE -> ISSUE -> WAIT_RESP -> RESPOND -> IDLE.
//  IDLE: if |reqValid_IN, grant first valid index scanning rrPtr, rrPtr+1, ... wrapping
//   at REQUESTERS-1 -> 0; latch addr/data/wen/grantId; go ISSUE. Else stay.
//  ISSUE: memReqValid=1 with latched fields; stays until memReqReady=1, then WAIT_RESP.
//  WAIT_RESP: memReqValid=0; on memRespValid latch memRespData, go RESPOND.
//   memRespValid is sampled only in WAIT_RESP; ignored in all other states.
//  RESPOND: respValid_OUT[grantId]=1 for exactly one cycle, respData_OUT=latched data;
//   rrPtr <= (grantId==REQUESTERS-1) ? 0 : grantId+1; go IDLE.
//  Min latency: request seen in IDLE cycle t -> memReqValid t+1; ready at t+1,
//   resp at t+2 -> respValid_OUT at t+3. Requester must drop valid the cycle after
//   its pulse; arbiter re-arbitrates from IDLE at t+4.
//  Inputs after grant are ignored; requester dropping valid mid-transaction does
//   not abort: transaction completes and pulse is still issued.
//  Simultaneous requests: rrPtr order only; no requester waits more than
//   REQUESTERS-1 transactions.
//  respData_OUT holds last value between pulses; for writes it holds the ack data.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined: 8+ bit counter clears on entering WAIT_RESP, increments
//   each WAIT_RESP cycle; if it reaches TIMEOUT_CYCLES without memRespValid ->
//   RESPOND with respErr_OUT=1, respData_OUT=0. memRespValid on the limit cycle wins
//   (respErr_OUT=0).
//  Not defined: no counter; WAIT_RESP waits indefinitely; respErr_OUT tied 0.
// TESTING
//  Reset mid-WAIT_RESP (rst low 1 cycle) -> busy=0, memReqValid=0, rrPtr=0 same edge.
//  Req0 read 0x0000_1040, ready immediate, resp 0xDEAD_BEEF next cycle -> respValid_OUT=2'b01
//   3 cycles after request, respData_OUT=0xDEAD_BEEF.
//  Req0 and req1 valid together, both held -> grants 0,1,0,1; rrPtr wraps 1->0.
//  Req1 write 0x0000_2000 data 0x1234_5678, memReqReady low 4 cycles -> memReqValid held,
//   fields stable, memReqWen=1; respValid_OUT=2'b10 after ack.
//  memRespValid pulsed during ISSUE -> ignored; only the WAIT_RESP response completes.
//  MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> respErr_OUT=1 pulse, data 0, IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among REQUESTERS cache controllers.
// Optional WAIT_RESP watchdog is built in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
   parameter int REQUESTERS      = 2,
   parameter int ADDRESS_WIDTH   = 32,
   parameter int CACHE_LINE_SIZE = 32,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [REQUESTERS-1:0]                 reqValid_IN,
   input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]   reqAddress_IN,
   input  logic [REQUESTERS*CACHE_LINE_SIZE-1:0] reqData_IN,
   input  logic [REQUESTERS-1:0]                 reqWen_IN,
   output logic [REQUESTERS-1:0]                 respValid_OUT,
   output logic [CACHE_LINE_SIZE-1:0]            respData_OUT,
   output logic                                  respErr_OUT,
   output logic                                  memReqValid,
   input  logic                                  memReqReady,
   output logic [ADDRESS_WIDTH-1:0]              memReqAddress,
   output logic [CACHE_LINE_SIZE-1:0]            memReqData,
   output logic                                  memReqWen,
   input  logic                                  memRespValid,
   input  logic [CACHE_LINE_SIZE-1:0]            memRespData,
   output logic [$clog2(REQUESTERS)-1:0]         grantId,
   output logic                                  busy
);
   localparam int GW = $clog2(REQUESTERS);
   localparam logic [GW:0]   ReqCount = (GW+1)'(REQUESTERS);
   localparam logic [GW-1:0] LastId   = GW'(REQUESTERS - 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ISSUE     = 2'd1;
   localparam logic [1:0] WAIT_RESP = 2'd2;
   localparam logic [1:0] RESPOND   = 2'd3;

   logic [1:0]              state;
   logic [GW-1:0]           rrPtr;
   logic [GW-1:0]           nextGrant;
   logic [GW-1:0]           scanOffset;
   logic [GW:0]             grantSum;
   logic [2*REQUESTERS-1:0] reqDouble;
   logic [REQUESTERS-1:0]   reqRot;
   logic                    scanFound;
   logic                    timeoutHit;

   // Rotate requests so bit 0 is rrPtr, pick the lowest set bit, then un-rotate.
   always_comb begin
      reqDouble  = {reqValid_IN, reqValid_IN} >> rrPtr;
      reqRot     = reqDouble[REQUESTERS-1:0];
      scanOffset = '0;
      scanFound  = 1'b0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (!scanFound && reqRot[k[GW-1:0]]) begin
            scanFound  = 1'b1;
            scanOffset = k[GW-1:0];
         end
      end
      grantSum = {1'b0, rrPtr} + {1'b0, scanOffset};
      if (grantSum >= ReqCount) grantSum = grantSum - ReqCount;
      nextGrant = grantSum[GW-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         rrPtr         <= '0;
         grantId       <= '0;
         memReqAddress <= '0;
         memReqData    <= '0;
         memReqWen     <= 1'b0;
         respData_OUT  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|reqValid_IN) begin
                  grantId       <= nextGrant;
                  memReqAddress <= reqAddress_IN[nextGrant*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                  memReqData    <= reqData_IN[nextGrant*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
                  memReqWen     <= reqWen_IN[nextGrant];
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (memReqReady) state <= WAIT_RESP;
            end
            WAIT_RESP: begin
               if (memRespValid) begin
                  respData_OUT <= memRespData;
                  state        <= RESPOND;
               end else if (timeoutHit) begin
                  respData_OUT <= '0;
                  state        <= RESPOND;
               end
            end
            RESPOND: begin
               rrPtr <= (grantId == LastId) ? '0 : grantId + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      respValid_OUT = '0;
      if (state == RESPOND) respValid_OUT[grantId] = 1'b1;
   end

   assign memReqValid = (state == ISSUE);
   assign busy        = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CW-1:0] WaitLimit = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] waitCnt;

   // waitCnt holds the number of WAIT_RESP cycles already elapsed; the limit cycle is the last one.
   assign timeoutHit = (state == WAIT_RESP) && !memRespValid && (waitCnt == WaitLimit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         waitCnt     <= '0;
         respErr_OUT <= 1'b0;
      end else begin
         if (state == WAIT_RESP) begin
            waitCnt <= waitCnt + 1'b1;
            if (memRespValid)    respErr_OUT <= 1'b0;
            else if (timeoutHit) respErr_OUT <= 1'b1;
         end else begin
            waitCnt <= '0;
         end
      end
   end
`else
   logic unusedTimeoutCfg;
   assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
   assign timeoutHit       = 1'b0;
   assign respErr_OUT      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a cycle-level protocol model.
module tb_mem_port_arbiter;
   localparam int R  = 2;
   localparam int AW = 32;
   localparam int LW = 32;
   localparam int TO = 8;

   logic            clk;
   logic            rst;
   logic [R-1:0]    reqValid;
   logic [R*AW-1:0] reqAddress;
   logic [R*LW-1:0] reqData;
   logic [R-1:0]    reqWen;
   logic [R-1:0]    respValid;
   logic [LW-1:0]   respData;
   logic            respErr;
   logic            memReqValid;
   logic            memReqReady;
   logic [AW-1:0]   memReqAddress;
   logic [LW-1:0]   memReqData;
   logic            memReqWen;
   logic            memRespValid;
   logic [LW-1:0]   memRespData;
   logic [$clog2(R)-1:0] grantId;
   logic            busy;

   mem_port_arbiter #(
      .REQUESTERS(R), .ADDRESS_WIDTH(AW), .CACHE_LINE_SIZE(LW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .reqValid_IN(reqValid), .reqAddress_IN(reqAddress), .reqData_IN(reqData), .reqWen_IN(reqWen),
      .respValid_OUT(respValid), .respData_OUT(respData), .respErr_OUT(respErr),
      .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddress(memReqAddress),
      .memReqData(memReqData), .memReqWen(memReqWen),
      .memRespValid(memRespValid), .memRespData(memRespData),
      .grantId(grantId), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCmp  = 0;
   int nFail = 0;

   // Model: phase 0 idle, 1 issuing, 2 awaiting memory, 3 responding.
   int          mPhase, mPtr, mGrant, mWaitN;
   logic [31:0] mAddr, mData, mRespData;
   logic        mWen, mErr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPhase = 0; mPtr = 0; mGrant = 0; mWaitN = 0;
      mAddr = '0; mData = '0; mRespData = '0; mWen = 1'b0; mErr = 1'b0;
   endtask

   function automatic logic [R-1:0] modelPulse();
      logic [R-1:0] p;
      p = '0;
      if (mPhase == 3) p[mGrant] = 1'b1;
      return p;
   endfunction

   task automatic checkOutputs();
      chk("busy", 64'(busy), 64'(mPhase != 0));
      chk("memReqValid", 64'(memReqValid), 64'(mPhase == 1));
      chk("respValid", 64'(respValid), 64'(modelPulse()));
      chk("grantId", 64'(grantId), 64'(mGrant));
      chk("respData", 64'(respData), 64'(mRespData));
      if (mPhase == 1) begin
         chk("memReqAddress", 64'(memReqAddress), 64'(mAddr));
         chk("memReqData", 64'(memReqData), 64'(mData));
         chk("memReqWen", 64'(memReqWen), 64'(mWen));
      end
      if (mPhase == 3) chk("respErr", 64'(respErr), 64'(mErr));
   endtask

   task automatic modelAdvance();
      case (mPhase)
         0: if (|reqValid) begin
               for (int k = 0; k < R; k++) begin
                  int idx;
                  idx = (mPtr + k) % R;
                  if (reqValid[idx] && mPhase == 0) begin
                     mGrant = idx;
                     mAddr  = reqAddress[idx*AW +: AW];
                     mData  = reqData[idx*LW +: LW];
                     mWen   = reqWen[idx];
                     mPhase = 1;
                  end
               end
            end
         1: if (memReqReady) begin mPhase = 2; mWaitN = 0; end
         2: begin
               mWaitN++;
               if (memRespValid) begin
                  mRespData = memRespData; mErr = 1'b0; mPhase = 3;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (mWaitN == TO) begin
                  mRespData = '0; mErr = 1'b1; mPhase = 3;
               end
`endif
            end
         default: begin mPtr = (mGrant + 1) % R; mPhase = 0; end
      endcase
   endtask

   task automatic step();
      checkOutputs();
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      reqValid = '0; reqAddress = '0; reqData = '0; reqWen = '0;
      memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
   endtask

   task automatic doTxn(input int i, input logic [31:0] addr, input logic [31:0] rdata);
      reqValid = '0; reqValid[i] = 1'b1;
      reqAddress[i*AW +: AW] = addr; reqWen[i] = 1'b0;
      memReqReady = 1'b1; memRespValid = 1'b0;
      step(); step();
      memRespValid = 1'b1; memRespData = rdata;
      step();
      memRespValid = 1'b0;
      step();
      reqValid = '0;
      step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [R-1:0] prevPulse, curPulse, want;
      int g, n;

      idleInputs();
      rst = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset memReqValid", 64'(memReqValid), 64'd0);
      chk("reset respValid", 64'(respValid), 64'd0);
      chk("reset grantId", 64'(grantId), 64'd0);
      chk("reset respData", 64'(respData), 64'd0);
      chk("reset memReqAddress", 64'(memReqAddress), 64'd0);
      rst = 1'b1;
      step();

      // Req0 read, immediate ready and response.
      reqValid = 2'b01; reqAddress = {32'h0, 32'h0000_1040}; memReqReady = 1'b1;
      step();
      chk("A memReqValid", 64'(memReqValid), 64'd1);
      chk("A memReqAddress", 64'(memReqAddress), 64'h0000_1040);
      chk("A memReqWen", 64'(memReqWen), 64'd0);
      step();
      memRespValid = 1'b1; memRespData = 32'hDEAD_BEEF;
      step();
      memRespValid = 1'b0;
      chk("A respValid", 64'(respValid), 64'b01);
      chk("A respData", 64'(respData), 64'hDEAD_BEEF);
      step();
      reqValid = '0;
      chk("A idle", 64'(busy), 64'd0);
      step();

      // Req1 write with four stalled issue cycles; late input changes must be ignored.
      reqValid = 2'b10; reqAddress = {32'h0000_2000, 32'h0}; reqData = {32'h1234_5678, 32'h0};
      reqWen = 2'b10; memReqReady = 1'b0;
      step();
      for (int s = 0; s < 4; s++) begin
         reqAddress = {$urandom, $urandom}; reqData = {$urandom, $urandom}; reqWen = '0;
         chk("B memReqValid", 64'(memReqValid), 64'd1);
         chk("B memReqAddress", 64'(memReqAddress), 64'h0000_2000);
         chk("B memReqData", 64'(memReqData), 64'h1234_5678);
         chk("B memReqWen", 64'(memReqWen), 64'd1);
         step();
      end
      memReqReady = 1'b1;
      step();
      memRespValid = 1'b1; memRespData = 32'hA5A5_0001;
      step();
      memRespValid = 1'b0;
      chk("B respValid", 64'(respValid), 64'b10);
      chk("B respData", 64'(respData), 64'hA5A5_0001);
      step();
      idleInputs();
      step();

      // Both requesters held: grants alternate 0,1,0,1 from pointer 0.
      prevPulse = '0;
      for (int j = 0; j < 4; j++) begin
         g = j % 2;
         reqValid = 2'b11 & ~prevPulse; memReqReady = 1'b1; memRespValid = 1'b0;
         reqAddress = {32'h0000_B000 + j, 32'h0000_A000 + j};
         step();
         reqValid = 2'b11;
         chk("D grantId", 64'(grantId), 64'(g));
         chk("D memReqAddress", 64'(memReqAddress), (g == 1) ? 64'(32'h0000_B000 + j) : 64'(32'h0000_A000 + j));
         step();
         memRespValid = 1'b1; memRespData = 32'hC0DE_0000 + j;
         step();
         memRespValid = 1'b0;
         chk("D respValid", 64'(respValid), (g == 1) ? 64'b10 : 64'b01);
         prevPulse = respValid;
         step();
      end
      idleInputs();
      step();

      // Memory responses outside WAIT_RESP are ignored.
      reqValid = 2'b01; reqAddress = {32'h0, 32'h0000_3000};
      memRespValid = 1'b1; memRespData = 32'h0000_BAD0;
      step();
      memReqReady = 1'b0; memRespData = 32'h0000_BAD1;
      step();
      memReqReady = 1'b1; memRespData = 32'h0000_BAD2;
      step();
      memRespValid = 1'b0; memReqReady = 1'b0;
      chk("C waiting", 64'(busy & ~memReqValid), 64'd1);
      step();
      memRespValid = 1'b1; memRespData = 32'h600D_600D;
      step();
      memRespValid = 1'b0;
      chk("C respValid", 64'(respValid), 64'b01);
      chk("C respData", 64'(respData), 64'h600D_600D);
      step();
      idleInputs();
      step();

      // Pointer now 1: simultaneous requests grant requester 1 first.
      reqValid = 2'b11; memReqReady = 1'b1;
      step();
      chk("E grantId", 64'(grantId), 64'd1);
      step();
      memRespValid = 1'b1; memRespData = 32'h0000_E001;
      step();
      memRespValid = 1'b0;
      step();
      idleInputs();
      step();

      // Reset during WAIT_RESP restores the pointer to 0.
      doTxn(0, 32'h0000_4000, 32'h0000_4444);
      reqValid = 2'b10; memReqReady = 1'b1;
      step(); step();
      memReqReady = 1'b0;
      rst = 1'b0;
      #1;
      chk("F busy", 64'(busy), 64'd0);
      chk("F memReqValid", 64'(memReqValid), 64'd0);
      chk("F grantId", 64'(grantId), 64'd0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      reqValid = 2'b11; memReqReady = 1'b1;
      step();
      chk("F grant after reset", 64'(grantId), 64'd0);
      step();
      memRespValid = 1'b1; memRespData = 32'h0000_F00F;
      step();
      memRespValid = 1'b0;
      step();
      idleInputs();
      step();

`ifdef MEM_ARB_TIMEOUT_EN
      reqValid = 2'b01; memReqReady = 1'b1;
      step(); step();
      memReqReady = 1'b0;
      n = 0;
      while (respValid == '0 && n < 40) begin
         n++;
         step();
      end
      chk("T wait cycles", 64'(n), 64'(TO));
      chk("T respErr", 64'(respErr), 64'd1);
      chk("T respData", 64'(respData), 64'd0);
      step();
      idleInputs();
      step();
`endif

      // Randomized traffic with stalls, spurious responses and mid-transaction drops.
      want = '0; prevPulse = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < R; i++) begin
            if (prevPulse[i]) want[i] = 1'b0;
            else if (!want[i]) want[i] = ($urandom_range(2) == 0);
            else if (mPhase != 0 && mGrant == i && $urandom_range(15) == 0) want[i] = 1'b0;
         end
         reqValid     = want;
         reqAddress   = {$urandom, $urandom};
         reqData      = {$urandom, $urandom};
         reqWen       = R'($urandom_range(3));
         memReqReady  = ($urandom_range(2) != 0);
         memRespValid = (mPhase == 2) ? ($urandom_range(2) == 0) : ($urandom_range(3) == 0);
         memRespData  = $urandom;
         curPulse     = modelPulse();
         step();
         prevPulse    = curPulse;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end
endmodule
